// File: rtl/timer_tick_sched_pkg.sv
// Shared types and constants for the timer tick scheduler: FSM states,
// interval-timer register map and control-register bit positions.
package timer_tick_sched_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_RD_ST,
        ST_WAIT_RD,
        ST_CLR,
        ST_TICK,
        ST_STOP,
        ST_SNAP_WR,
        ST_SNAP_RD4,
        ST_SNAP_RD5,
        ST_SNAP_DONE
    } state_t;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    localparam logic [15:0] CTRL_START_DEFAULT =
        (16'(1) << CTRL_START) | (16'(1) << CTRL_CONT) | (16'(1) << CTRL_ITO);
    localparam logic [15:0] CTRL_STOP_VAL = 16'(1) << CTRL_STOP;

endpackage

// File: rtl/timer_tick_sched_chan.sv
// One tick channel: programmable period register plus down-counter that
// emits a single-cycle fire pulse every <period> system ticks.
module tick_chan
    import timer_tick_sched_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_cfg_we,
    input  logic [PERIOD_W-1:0] i_cfg_period,
    input  logic                i_tick,
    output logic                o_fire
);

    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_cnt;
    logic                r_fire;

    // A config write reloads the counter and suppresses any tick in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_period <= '0;
            r_cnt    <= '0;
            r_fire   <= 1'b0;
        end else begin
            r_fire <= 1'b0;
            if (i_cfg_we) begin
                r_period <= i_cfg_period;
                r_cnt    <= i_cfg_period;
            end else if (i_tick && (r_period != '0)) begin
                if (r_cnt == PERIOD_W'(1)) begin
                    r_fire <= 1'b1;
                    r_cnt  <= r_period;
                end else begin
                    r_cnt <= r_cnt - PERIOD_W'(1);
                end
            end
        end
    end

    assign o_fire = r_fire;

endmodule

// File: rtl/timer_tick_sched.sv
// Avalon-MM master servicing one interval timer and fanning its timeouts out
// to NUM_CHAN tick channels. Define TIMER_TICK_SCHED_SNAP_EN for counter snapshots.
module timer_tick_sched
    import timer_tick_sched_pkg::*;
#(
    parameter int          NUM_CHAN       = 4,
    parameter int          PERIOD_W       = 16,
    parameter logic [15:0] CTRL_START_VAL = CTRL_START_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    output logic [2:0]          tm_address,
    output logic                tm_chipselect,
    output logic                tm_write_n,
    output logic [15:0]         tm_writedata,
    input  logic [15:0]         tm_readdata,
    input  logic                tm_irq,
    input  logic                cfg_we,
    input  logic [2:0]          cfg_chan,
    input  logic [PERIOD_W-1:0] cfg_period,
`ifdef TIMER_TICK_SCHED_SNAP_EN
    input  logic                snap_req,
    output logic                snap_valid,
    output logic [31:0]         snap_value,
`endif
    output logic [NUM_CHAN-1:0] chan_fire,
    output logic [31:0]         tick_count,
    output logic                running,
    output logic                spurious
);

    state_t      r_state;
    state_t      w_state_next;
    logic        r_to;
    logic [31:0] r_tick_count;
    logic        r_running;
    logic        r_spurious;
    logic        w_tick;

`ifdef TIMER_TICK_SCHED_SNAP_EN
    logic        r_snap_pend;
    logic        r_snap_valid;
    logic [15:0] r_snap_lo;
    logic [31:0] r_snap_value;
    logic        w_snap_go;

    // Snapshots only start from an idle RUN cycle; IRQ service always wins.
    assign w_snap_go = (r_state == ST_RUN) && enable && !tm_irq && (r_snap_pend || snap_req);
`else
    logic w_unused_rd;
    assign w_unused_rd = ^tm_readdata[15:1];
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        tm_chipselect = 1'b0;
        tm_write_n    = 1'b1;
        tm_address    = 3'd0;
        tm_writedata  = 16'd0;
        case (r_state)
            ST_IDLE: if (enable) w_state_next = ST_START;
            ST_START: begin
                tm_chipselect = 1'b1;
                tm_write_n    = 1'b0;
                tm_address    = ADDR_CONTROL;
                tm_writedata  = CTRL_START_VAL;
                w_state_next  = ST_RUN;
            end
            ST_RUN: begin
                if (!enable)     w_state_next = ST_STOP;
                else if (tm_irq) w_state_next = ST_RD_ST;
`ifdef TIMER_TICK_SCHED_SNAP_EN
                else if (w_snap_go) w_state_next = ST_SNAP_WR;
`endif
            end
            ST_RD_ST: begin
                tm_chipselect = 1'b1;
                tm_address    = ADDR_STATUS;
                w_state_next  = ST_WAIT_RD;
            end
            ST_WAIT_RD: w_state_next = ST_CLR;
            ST_CLR: begin
                tm_chipselect = 1'b1;
                tm_write_n    = 1'b0;
                tm_address    = ADDR_STATUS;
                w_state_next  = ST_TICK;
            end
            // Guard cycle: the IRQ cleared by the CLR write is not re-sampled here.
            ST_TICK: w_state_next = ST_RUN;
            ST_STOP: begin
                tm_chipselect = 1'b1;
                tm_write_n    = 1'b0;
                tm_address    = ADDR_CONTROL;
                tm_writedata  = CTRL_STOP_VAL;
                w_state_next  = ST_IDLE;
            end
`ifdef TIMER_TICK_SCHED_SNAP_EN
            ST_SNAP_WR: begin
                tm_chipselect = 1'b1;
                tm_write_n    = 1'b0;
                tm_address    = ADDR_SNAPL;
                w_state_next  = ST_SNAP_RD4;
            end
            ST_SNAP_RD4: begin
                tm_chipselect = 1'b1;
                tm_address    = ADDR_SNAPL;
                w_state_next  = ST_SNAP_RD5;
            end
            ST_SNAP_RD5: begin
                tm_chipselect = 1'b1;
                tm_address    = ADDR_SNAPH;
                w_state_next  = ST_SNAP_DONE;
            end
            ST_SNAP_DONE: w_state_next = ST_RUN;
`endif
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_to         <= 1'b0;
            r_tick_count <= 32'd0;
            r_running    <= 1'b0;
            r_spurious   <= 1'b0;
        end else begin
            r_spurious <= 1'b0;
            if (r_state == ST_WAIT_RD) r_to <= tm_readdata[0];
            if (r_state == ST_TICK) begin
                if (r_to) r_tick_count <= r_tick_count + 32'd1;
                else      r_spurious   <= 1'b1;
            end
            if (r_state == ST_START)     r_running <= 1'b1;
            else if (r_state == ST_STOP) r_running <= 1'b0;
        end
    end

`ifdef TIMER_TICK_SCHED_SNAP_EN
    // Low half arrives during the SNAPH read cycle, high half one cycle later.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_snap_pend  <= 1'b0;
            r_snap_valid <= 1'b0;
            r_snap_lo    <= 16'd0;
            r_snap_value <= 32'd0;
        end else begin
            r_snap_valid <= 1'b0;
            r_snap_pend  <= enable && !w_snap_go && (r_snap_pend || snap_req);
            if (r_state == ST_SNAP_RD5) r_snap_lo <= tm_readdata;
            if (r_state == ST_SNAP_DONE) begin
                r_snap_value <= {tm_readdata, r_snap_lo};
                r_snap_valid <= 1'b1;
            end
        end
    end

    assign snap_valid = r_snap_valid;
    assign snap_value = r_snap_value;
`endif

    assign w_tick = (r_state == ST_TICK) && r_to;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
            tick_chan #(
                .PERIOD_W(PERIOD_W)
            ) u_chan (
                .clk          (clk),
                .reset_n      (reset_n),
                .i_cfg_we     (cfg_we && (cfg_chan == 3'(gi))),
                .i_cfg_period (cfg_period),
                .i_tick       (w_tick),
                .o_fire       (chan_fire[gi])
            );
        end
    endgenerate

    assign tick_count = r_tick_count;
    assign running    = r_running;
    assign spurious   = r_spurious;

endmodule

// File: tb/tb_timer_tick_sched.sv
// Self-checking bench for timer_tick_sched: timer peripheral model, bus monitor,
// tick/fire reference model, table vectors, corner sequences and random traffic.
module tb_timer_tick_sched;

    localparam int NUM_CHAN = 4;
    localparam int PERIOD_W = 16;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                enable = 1'b0;
    logic [2:0]          tm_address;
    logic                tm_chipselect;
    logic                tm_write_n;
    logic [15:0]         tm_writedata;
    logic [15:0]         tm_readdata = 16'd0;
    logic                tm_irq = 1'b0;
    logic                cfg_we = 1'b0;
    logic [2:0]          cfg_chan = 3'd0;
    logic [PERIOD_W-1:0] cfg_period = '0;
    logic [NUM_CHAN-1:0] chan_fire;
    logic [31:0]         tick_count;
    logic                running;
    logic                spurious;
`ifdef TIMER_TICK_SCHED_SNAP_EN
    logic                snap_req = 1'b0;
    logic                snap_valid;
    logic [31:0]         snap_value;
`endif

    timer_tick_sched #(.NUM_CHAN(NUM_CHAN), .PERIOD_W(PERIOD_W)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .tm_address(tm_address), .tm_chipselect(tm_chipselect),
        .tm_write_n(tm_write_n), .tm_writedata(tm_writedata),
        .tm_readdata(tm_readdata), .tm_irq(tm_irq),
        .cfg_we(cfg_we), .cfg_chan(cfg_chan), .cfg_period(cfg_period),
`ifdef TIMER_TICK_SCHED_SNAP_EN
        .snap_req(snap_req), .snap_valid(snap_valid), .snap_value(snap_value),
`endif
        .chan_fire(chan_fire), .tick_count(tick_count),
        .running(running), .spurious(spurious)
    );

    always #5 clk = ~clk;

    // Timer peripheral: registered read data, one cycle after the read.
    bit status_to = 1'b1;
    always @(posedge clk) begin
        if (tm_chipselect && tm_write_n) begin
            case (tm_address)
                3'd0:    tm_readdata <= {15'd0, status_to};
                3'd4:    tm_readdata <= 16'h0000;
                3'd5:    tm_readdata <= 16'h02FA;
                default: tm_readdata <= 16'hDEAD;
            endcase
        end
    end

    // Bus monitor: entry = {is_write, address, write data (0 for reads)}.
    logic [19:0] acc_q[$];
    int idle_err = 0;
    int spur_seen = 0;
    int fire_seen[NUM_CHAN];
    always @(negedge clk) begin
        if (reset_n) begin
            if (tm_chipselect)
                acc_q.push_back({~tm_write_n, tm_address, tm_write_n ? 16'h0 : tm_writedata});
            else if (tm_address != 3'd0 || tm_writedata != 16'd0 || !tm_write_n)
                idle_err++;
            for (int i = 0; i < NUM_CHAN; i++) fire_seen[i] += int'(chan_fire[i]);
            spur_seen += int'(spurious);
        end
    end

    int n_pass = 0;
    int n_total = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: channel i fires on every tick whose distance from its
    // last configuration is a positive multiple of its period.
    int m_ticks = 0;
    int m_spur = 0;
    int m_per[8];
    int m_base[8];
    int m_fire_total[NUM_CHAN];

    function automatic void model_cfg(input int cc, input int cp);
        if (cc < NUM_CHAN) begin
            m_per[cc]  = cp;
            m_base[cc] = m_ticks;
        end
    endfunction

    function automatic logic [NUM_CHAN-1:0] model_service(input bit to_v, input bit cfg_tick,
                                                          input int cc, input int cp);
        logic [NUM_CHAN-1:0] mask = '0;
        if (to_v) begin
            m_ticks++;
            for (int i = 0; i < NUM_CHAN; i++)
                if (!(cfg_tick && cc == i) && m_per[i] > 0 && ((m_ticks - m_base[i]) % m_per[i]) == 0) begin
                    mask[i] = 1'b1;
                    m_fire_total[i]++;
                end
        end else begin
            m_spur++;
        end
        if (cfg_tick) model_cfg(cc, cp);
        return mask;
    endfunction

    task automatic cfg(input int cc, input int cp);
        cfg_we = 1'b1; cfg_chan = cc[2:0]; cfg_period = cp[PERIOD_W-1:0];
        @(negedge clk);
        cfg_we = 1'b0;
        model_cfg(cc, cp);
    endtask

    // One IRQ service; optionally drives a config write in the TICK cycle.
    task automatic service(input bit to_v, input bit cfg_tick, input int cc, input int cp,
                           output logic [NUM_CHAN-1:0] fire, output logic [31:0] ticks,
                           output logic spur, output bit bus_ok);
        bit found = 1'b0;
        acc_q.delete();
        status_to = to_v;
        tm_irq = 1'b1;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (tm_chipselect && !tm_write_n && tm_address == 3'd0) found = 1'b1;
        end
        tm_irq = 1'b0;
        @(negedge clk);
        if (cfg_tick) begin
            cfg_we = 1'b1; cfg_chan = cc[2:0]; cfg_period = cp[PERIOD_W-1:0];
        end
        @(negedge clk);
        cfg_we = 1'b0;
        fire = chan_fire; ticks = tick_count; spur = spurious;
        bus_ok = found && acc_q.size() == 2 && acc_q[0][19:16] == 4'b0000 && acc_q[1] == 20'h80000;
    endtask

    task automatic do_service(input string tag, input bit to_v, input bit cfg_tick,
                              input int cc, input int cp, output logic [NUM_CHAN-1:0] fire);
        logic [NUM_CHAN-1:0] exp_fire;
        logic [31:0] ticks;
        logic spur;
        bit bus_ok;
        exp_fire = model_service(to_v, cfg_tick, cc, cp);
        service(to_v, cfg_tick, cc, cp, fire, ticks, spur, bus_ok);
        check({tag, "_fire"}, fire, exp_fire);
        check({tag, "_ticks"}, ticks, 32'(m_ticks));
        check({tag, "_spur"}, spur, !to_v);
        check({tag, "_bus"}, bus_ok, 1);
    endtask

    typedef struct {
        bit                  to_v;
        logic [NUM_CHAN-1:0] exp_fire;
        logic [31:0]         exp_ticks;
        bit                  exp_spur;
    } vec_t;
    vec_t vecs[7];

    initial begin
        logic [NUM_CHAN-1:0] fire;
        logic [31:0] ticks;
        logic spur;
        bit bus_ok;
        bit done;
        int snap_cnt;

        // ch0 P=3, ch1 P=1, ch2 P=0: five ticks, a spurious IRQ, then tick 6.
        vecs[0] = '{1'b1, 4'b0010, 32'd1, 1'b0};
        vecs[1] = '{1'b1, 4'b0010, 32'd2, 1'b0};
        vecs[2] = '{1'b1, 4'b0011, 32'd3, 1'b0};
        vecs[3] = '{1'b1, 4'b0010, 32'd4, 1'b0};
        vecs[4] = '{1'b1, 4'b0010, 32'd5, 1'b0};
        vecs[5] = '{1'b0, 4'b0000, 32'd5, 1'b1};
        vecs[6] = '{1'b1, 4'b0011, 32'd6, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_bus", {tm_chipselect, tm_write_n, tm_address, tm_writedata}, {1'b0, 1'b1, 3'd0, 16'd0});
        check("rst_out", {running, spurious, chan_fire, tick_count}, '0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_bus", {tm_chipselect, tm_write_n}, 2'b01);
        acc_q.delete();
        enable = 1'b1;
        @(negedge clk);
        check("start_wr", {tm_chipselect, tm_write_n, tm_address, tm_writedata}, {1'b1, 1'b0, 3'd1, 16'h0007});
        @(negedge clk);
        check("start_run", {running, tm_chipselect}, 2'b10);
        repeat (5) @(negedge clk);
        check("start_quiet", acc_q.size(), 1);

        cfg(0, 3); cfg(1, 1); cfg(2, 0);
        for (int v = 0; v < 7; v++) begin
            void'(model_service(vecs[v].to_v, 1'b0, 0, 0));
            service(vecs[v].to_v, 1'b0, 0, 0, fire, ticks, spur, bus_ok);
            $display("vec %0d: to=%0b fire=%b ticks=%0d spur=%0b", v, vecs[v].to_v, fire, ticks, spur);
            check($sformatf("vec%0d_fire", v), fire, vecs[v].exp_fire);
            check($sformatf("vec%0d_ticks", v), ticks, vecs[v].exp_ticks);
            check($sformatf("vec%0d_spur", v), spur, vecs[v].exp_spur);
            check($sformatf("vec%0d_bus", v), bus_ok, 1);
        end

        // ch0 reaches cnt==1 on tick 9; a config write in that TICK cycle wins.
        do_service("t7", 1'b1, 1'b0, 0, 0, fire);
        do_service("t8", 1'b1, 1'b0, 0, 0, fire);
        do_service("t9_cfg", 1'b1, 1'b1, 0, 2, fire);
        check("t9_no_fire0", fire[0], 1'b0);
        do_service("t10", 1'b1, 1'b0, 0, 0, fire);
        do_service("t11", 1'b1, 1'b0, 0, 0, fire);
        check("t11_fire0", fire[0], 1'b1);

        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 4)));
            end else begin
                do_service($sformatf("rnd%0d", r), $urandom_range(0, 5) != 0,
                           $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)),
                           int'($urandom_range(0, 4)), fire);
                $display("rnd %0d: fire=%b ticks=%0d", r, fire, tick_count);
            end
        end

`ifdef TIMER_TICK_SCHED_SNAP_EN
        acc_q.delete();
        snap_req = 1'b1;
        done = 1'b0;
        snap_cnt = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            snap_req = 1'b0;
            if (snap_valid) begin done = 1'b1; snap_cnt++; end
        end
        check("snap_value", snap_value, 32'h02FA0000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (snap_valid) snap_cnt++;
        end
        check("snap_valid_cnt", snap_cnt, 1);
        check("snap_bus", {acc_q.size() == 3, acc_q[0][19:16], acc_q[1][19:16], acc_q[2][19:16]},
              {1'b1, 4'hC, 4'h4, 4'h5});
        $display("snap: value=%h valid_pulses=%0d", snap_value, snap_cnt);
`endif

        // enable drops in WAIT_RD: service completes, then the timer is stopped.
        acc_q.delete();
        status_to = 1'b1;
        tm_irq = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (tm_chipselect && tm_write_n && tm_address == 3'd0) done = 1'b1;
        end
        @(negedge clk);
        enable = 1'b0;
        void'(model_service(1'b1, 1'b0, 0, 0));
        for (int k = 0; k < 30 && running; k++) begin
            @(negedge clk);
            if (tm_chipselect && !tm_write_n && tm_address == 3'd0) tm_irq = 1'b0;
        end
        tm_irq = 1'b0;
        repeat (3) @(negedge clk);
        check("stop_running", running, 1'b0);
        check("stop_ticks", tick_count, 32'(m_ticks));
        check("stop_bus", {acc_q.size() == 3, acc_q[0][19:16], acc_q[1], acc_q[2]},
              {1'b1, 4'h0, 20'h80000, 20'h90008});
        $display("stop: running=%0b ticks=%0d accesses=%0d", running, tick_count, acc_q.size());

        for (int i = 0; i < NUM_CHAN; i++)
            check($sformatf("fire_total%0d", i), fire_seen[i], m_fire_total[i]);
        check("spur_total", spur_seen, m_spur);
        check("idle_bus_rule", idle_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
